// File: rtl/button_start_ctrl.sv
// Pushbutton front end for the IR sequencer: synchronizes and debounces an active-low
// button, issues a start pulse on a short press and toggles loop mode on a long press.
module button_start_ctrl #(
  parameter int DEBOUNCE_CYCLES   = 50000,
  parameter int LONG_PRESS_CYCLES = 1500000
) (
  input  logic       clock_in,
  input  logic       reset_in,
  input  logic       button_in,
  input  logic       busy_in,
  output logic       start_out,
  output logic       loop_forever_out,
  output logic       pressed_out,
  output logic [1:0] state_dbg
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_PRESS_CYCLES);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1,
    LONG_HELD = 2'd2
  } state_t;

  logic          sync1, sync2;
  logic          raw_pressed;
  logic          deb_diff;
  logic          deb_flip;
  logic [DW-1:0] deb_cnt;

  state_t        state, state_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic          start_n, loop_n;

  // Synchronizer idles at 1 so a reset looks like a released button.
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= button_in;
      sync2 <= sync1;
    end
  end

  assign raw_pressed = ~sync2;
  assign deb_diff    = (raw_pressed != pressed_out);
  assign deb_flip    = deb_diff && (deb_cnt == DEB_LAST);

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      deb_cnt     <= '0;
      pressed_out <= 1'b0;
    end else if (deb_diff) begin
      if (deb_flip) begin
        pressed_out <= ~pressed_out;
        deb_cnt     <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end else begin
      deb_cnt <= '0;
    end
  end

  // Start pulse is decided one cycle after the debounced release so busy_in is
  // sampled in the first released cycle; a busy sequencer simply drops the press.
  always_comb begin
    state_n = state;
    hold_n  = hold_cnt;
    start_n = 1'b0;
    loop_n  = loop_forever_out;
    case (state)
      IDLE: begin
        if (deb_flip && !pressed_out) begin
          state_n = PRESSED;
          hold_n  = '0;
        end
      end
      PRESSED: begin
        if (!pressed_out) begin
          state_n = IDLE;
          start_n = !busy_in;
        end else begin
          hold_n = hold_cnt + 1'b1;
          if (hold_n == HOLD_MAX) begin
            state_n = LONG_HELD;
            loop_n  = ~loop_forever_out;
          end
        end
      end
      LONG_HELD: begin
        if (!pressed_out) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state            <= IDLE;
      hold_cnt         <= '0;
      start_out        <= 1'b0;
      loop_forever_out <= 1'b0;
    end else begin
      state            <= state_n;
      hold_cnt         <= hold_n;
      start_out        <= start_n;
      loop_forever_out <= loop_n;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_button_start_ctrl.sv
// Directed scenarios plus random button/busy activity, checked cycle by cycle
// against a press-length reference model.
module tb_button_start_ctrl;

  localparam int DEB  = 4;
  localparam int LONG = 16;

  logic       clock_in = 1'b0;
  logic       reset_in = 1'b0;
  logic       button_in = 1'b1;
  logic       busy_in = 1'b0;
  logic       start_out, loop_forever_out, pressed_out;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  logic m_pipe0, m_pipe1, m_pressed, m_prev_p, m_loop, m_start;
  int   m_run, m_len;

  // observation bookkeeping
  logic last_start = 1'b0, last_pressed = 1'b0;
  int   n_starts = 0, n_rises = 0;

  button_start_ctrl #(.DEBOUNCE_CYCLES(DEB), .LONG_PRESS_CYCLES(LONG)) dut (
    .clock_in(clock_in), .reset_in(reset_in), .button_in(button_in), .busy_in(busy_in),
    .start_out(start_out), .loop_forever_out(loop_forever_out),
    .pressed_out(pressed_out), .state_dbg(state_dbg)
  );

  always #5 clock_in = ~clock_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pipe0 = 1'b0; m_pipe1 = 1'b0; m_pressed = 1'b0; m_prev_p = 1'b0;
    m_loop = 1'b0; m_start = 1'b0; m_run = 0; m_len = 0;
  endtask

  // Advance the model across one rising edge using the inputs present at that edge.
  task automatic model_step();
    logic cur, synced, new_start;
    if (!reset_in) begin
      model_reset();
    end else begin
      cur = m_pressed;
      new_start = m_prev_p && !cur && (m_len < LONG) && !busy_in;
      if (cur) begin
        if (!m_prev_p) m_len = 0;
        if (m_len < LONG) begin
          m_len++;
          if (m_len == LONG) m_loop = !m_loop;
        end
      end
      synced  = m_pipe1;
      m_pipe1 = m_pipe0;
      m_pipe0 = !button_in;
      if (synced != m_pressed) begin
        m_run++;
        if (m_run == DEB) begin
          m_pressed = !m_pressed;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      m_prev_p = cur;
      m_start  = new_start;
    end
  endtask

  task automatic cycle();
    @(posedge clock_in);
    model_step();
    @(negedge clock_in);
    check("start", start_out, m_start);
    check("loop", loop_forever_out, m_loop);
    check("pressed", pressed_out, m_pressed);
    check("start_gap", start_out & last_start, 0);
    if (start_out) n_starts++;
    if (pressed_out && !last_pressed) n_rises++;
    last_start   = start_out;
    last_pressed = pressed_out;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  initial begin
    int s0, r0, len;
    model_reset();

    // reset held from time 0, button released
    run(3);
    check("reset_state", state_dbg, 0);
    reset_in = 1'b1;
    run(6);
    check("post_reset_pressed", pressed_out, 0);

    // glitch: 3 cycles low must be filtered
    s0 = n_starts; r0 = n_rises;
    button_in = 1'b0; run(3);
    button_in = 1'b1; run(12);
    check("glitch_rises", n_rises - r0, 0);
    check("glitch_starts", n_starts - s0, 0);

    // bouncy press: toggle every 2 cycles for 20 cycles, then stable low
    s0 = n_starts; r0 = n_rises;
    for (int i = 0; i < 10; i++) begin
      button_in = i[0];
      run(2);
    end
    button_in = 1'b0;
    run(5);
    check("bounce_lat_early", pressed_out, 0);
    run(1);
    check("bounce_lat", pressed_out, 1);
    run(4);
    button_in = 1'b1;
    run(12);
    check("bounce_rises", n_rises - r0, 1);
    check("bounce_starts", n_starts - s0, 1);

    // busy: short press is discarded
    s0 = n_starts;
    busy_in = 1'b1;
    button_in = 1'b0; run(8);
    button_in = 1'b1; run(12);
    check("busy_starts", n_starts - s0, 0);
    check("busy_loop", loop_forever_out, 0);
    busy_in = 1'b0;

    // long press toggles loop mode, twice returns it to 0
    for (int k = 0; k < 2; k++) begin
      s0 = n_starts;
      button_in = 1'b0; run(30);
      button_in = 1'b1; run(12);
      check("long_starts", n_starts - s0, 0);
      check("long_loop", loop_forever_out, (k == 0) ? 1 : 0);
    end

    // reset in the middle of a hold
    button_in = 1'b0;
    run(6 + 10);
    check("hold_pressed", pressed_out, 1);
    @(posedge clock_in);
    model_step();
    #2 reset_in = 1'b0;
    model_reset();
    #1;
    check("async_start", start_out, 0);
    check("async_loop", loop_forever_out, 0);
    check("async_pressed", pressed_out, 0);
    last_start = 1'b0; last_pressed = 1'b0;
    run(2);
    reset_in = 1'b1;
    s0 = n_starts;
    run(5);
    check("rehold_lat_early", pressed_out, 0);
    run(1);
    check("rehold_lat", pressed_out, 1);
    run(3);
    button_in = 1'b1;
    run(12);
    check("rehold_starts", n_starts - s0, 1);

    // random activity with random busy
    for (int i = 0; i < 24; i++) begin
      button_in = i[0];
      busy_in   = 1'($urandom_range(0, 1));
      len       = $urandom_range(1, 26);
      run(len);
    end
    button_in = 1'b1;
    busy_in = 1'b0;
    run(14);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
